// File: rtl/object_ctrl_pkg.sv
// obj_ctrl_pkg: game geometry constants, FSM state type and y-clamp helper shared by object_ctrl files
package obj_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, OVER} state_e;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int D_W = 40;
  localparam int D_H = 30;
  localparam int R_W = 90;
  localparam int R_H = 30;
  localparam logic [9:0] OFFSCREEN_X = 10'd700;
  localparam logic [9:0] Y_MAX = 10'd450;
  localparam logic [9:0] D_X = 10'd40;
  localparam logic [9:0] SPAWN_Y = 10'd225;
  localparam logic [9:0] R_SPAWN_X = 10'd600;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  function automatic logic [9:0] clamp_y(input logic [10:0] y);
    return (y > {1'b0, Y_MAX}) ? Y_MAX : y[9:0];
  endfunction
endpackage

// File: rtl/object_ctrl_if.sv
// object_ctrl_if: frame tick, keys and collision code in; sprite positions, valids, score, lives, game_over out
interface object_ctrl_if;
  logic frame_tick, key_up, key_down, key_fire, key_start;
  logic [1:0] Event;
  logic [9:0] d_x, d_y, r_x, r_y, m_x, m_y;
  logic d_valid, r_valid;
  logic [7:0] score;
  logic [1:0] lives;
  logic game_over;
  modport master(output frame_tick, key_up, key_down, key_fire, key_start, Event,
                 input d_x, d_y, r_x, r_y, m_x, m_y, d_valid, r_valid, score, lives, game_over);
  modport slave(input frame_tick, key_up, key_down, key_fire, key_start, Event,
                output d_x, d_y, r_x, r_y, m_x, m_y, d_valid, r_valid, score, lives, game_over);
endinterface

// File: rtl/object_ctrl_lfsr8.sv
// lfsr8: x^8+x^6+x^5+x^4+1 Fibonacci LFSR; clk_25Hz/rst, load reseeds, adv steps once, lfsr is the state
module lfsr8
  import obj_ctrl_pkg::*;
(
  input  logic       clk_25Hz,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] lfsr
);
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load ? LFSR_SEED : adv ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
  always_ff @(posedge clk_25Hz) lfsr_q <= rst ? LFSR_SEED : lfsr_d;
  assign lfsr = lfsr_q;
endmodule

// File: rtl/object_ctrl.sv
// object_ctrl: dragon/robot/missile game FSM; clk_25Hz, sync rst, bus carries ticks/keys/Event in and sprite state out
module object_ctrl
  import obj_ctrl_pkg::*;
#(
  parameter int D_STEP = 4,
  parameter int R_STEP = 2,
  parameter int M_STEP = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int LIVES_INIT = 3
) (
  input logic clk_25Hz,
  input logic rst,
  object_ctrl_if.slave bus
);
  localparam logic [9:0] DS = 10'(D_STEP);
  localparam logic [9:0] RS = 10'(R_STEP);
  localparam logic [15:0] RF = 16'(RESPAWN_FRAMES);
  localparam logic [1:0] LI = 2'(LIVES_INIT);
  localparam logic [9:0] M_FIRE_X = D_X + 10'(D_W);
  state_e state_q, state_d;
  logic [9:0] d_y_q, d_y_d, r_x_q, r_x_d, r_y_q, r_y_d, m_x_q, m_x_d, m_y_q, m_y_d;
  logic d_valid_q, d_valid_d, r_valid_q, r_valid_d, game_over_q, game_over_d;
  logic [7:0] score_q, score_d, lfsr;
  logic [1:0] lives_q, lives_d, ev_prev_q, ev_prev_d, lives_dec;
  logic [15:0] rcnt_q, rcnt_d, fcnt_q, fcnt_d;
  logic new_ev, ev_r, ev_d, tick, m_act, restart, r_wrap;
  logic [10:0] m_sum;
  logic [9:0] d_up, d_dn, lfsr_y;
  lfsr8 u_lfsr (
    .clk_25Hz(clk_25Hz),
    .rst(rst),
    .load(bus.key_start && state_q == OVER),
    .adv(bus.frame_tick),
    .lfsr(lfsr)
  );
  always_comb begin
    tick = bus.frame_tick;
    new_ev = bus.Event != 2'b00 && bus.Event != ev_prev_q;
    ev_r = state_q == PLAY && new_ev && bus.Event[0];
    ev_d = state_q == PLAY && new_ev && bus.Event[1];
    restart = bus.key_start && (state_q == IDLE || state_q == OVER);
    m_act = m_x_q != OFFSCREEN_X;
    m_sum = {1'b0, m_x_q} + 11'(M_STEP);
    d_up = d_y_q < DS ? 10'd0 : d_y_q - DS;
    d_dn = clamp_y({1'b0, d_y_q} + {1'b0, DS});
    lfsr_y = clamp_y({2'b00, lfsr, 1'b0});
    r_wrap = r_x_q < RS;
    lives_dec = lives_q - 2'd1;
    state_d = state_q;
    d_y_d = d_y_q;
    r_x_d = r_x_q;
    r_y_d = r_y_q;
    m_x_d = m_x_q;
    m_y_d = m_y_q;
    d_valid_d = d_valid_q;
    r_valid_d = r_valid_q;
    score_d = score_q;
    lives_d = lives_q;
    game_over_d = game_over_q;
    rcnt_d = rcnt_q;
    fcnt_d = fcnt_q;
    ev_prev_d = bus.Event;
    if (restart) begin
      state_d = PLAY;
      d_y_d = SPAWN_Y;
      r_x_d = R_SPAWN_X;
      r_y_d = SPAWN_Y;
      m_x_d = OFFSCREEN_X;
      m_y_d = 10'd0;
      d_valid_d = 1'b1;
      r_valid_d = 1'b1;
      score_d = 8'd0;
      lives_d = LI;
      game_over_d = 1'b0;
      rcnt_d = 16'd0;
      fcnt_d = 16'd0;
    end else if (state_q == PLAY) begin
      if (tick && !ev_d && bus.key_up != bus.key_down) d_y_d = bus.key_up ? d_up : d_dn;
      if (ev_r) begin
        score_d = score_q == 8'hFF ? score_q : score_q + 8'd1;
        r_valid_d = 1'b0;
        rcnt_d = RF;
      end else if (tick && r_valid_q) begin
        r_x_d = r_wrap ? R_SPAWN_X : r_x_q - RS;
        r_y_d = r_wrap ? lfsr_y : r_y_q;
      end else if (tick) begin
        r_valid_d = rcnt_q <= 16'd1;
        r_x_d = rcnt_q <= 16'd1 ? R_SPAWN_X : r_x_q;
        r_y_d = rcnt_q <= 16'd1 ? SPAWN_Y : r_y_q;
        rcnt_d = rcnt_q <= 16'd1 ? 16'd0 : rcnt_q - 16'd1;
      end
      if (ev_r || ev_d || (tick && m_act && m_sum >= 11'(SCREEN_W))) begin
        m_x_d = OFFSCREEN_X;
        m_y_d = 10'd0;
      end else if (tick && m_act) begin
        m_x_d = m_sum[9:0];
      end else if (tick && bus.key_fire) begin
        m_x_d = M_FIRE_X;
        m_y_d = d_y_q;
      end
      if (ev_d) begin
        lives_d = lives_dec;
        d_valid_d = 1'b0;
        state_d = lives_dec == 2'd0 ? OVER : RESPAWN;
        game_over_d = lives_dec == 2'd0;
        fcnt_d = lives_dec == 2'd0 ? fcnt_q : RF;
      end
    end else if (state_q == RESPAWN && tick) begin
      fcnt_d = fcnt_q <= 16'd1 ? 16'd0 : fcnt_q - 16'd1;
      if (fcnt_q <= 16'd1) begin
        state_d = PLAY;
        d_valid_d = 1'b1;
        d_y_d = SPAWN_Y;
        r_x_d = R_SPAWN_X;
        r_y_d = SPAWN_Y;
        r_valid_d = 1'b1;
        rcnt_d = 16'd0;
      end
    end
  end
  always_ff @(posedge clk_25Hz) begin
    if (rst) begin
      state_q <= IDLE;
      d_y_q <= SPAWN_Y;
      r_x_q <= R_SPAWN_X;
      r_y_q <= SPAWN_Y;
      m_x_q <= OFFSCREEN_X;
      m_y_q <= 10'd0;
      d_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      score_q <= 8'd0;
      lives_q <= LI;
      game_over_q <= 1'b0;
      rcnt_q <= 16'd0;
      fcnt_q <= 16'd0;
      ev_prev_q <= 2'b00;
    end else begin
      state_q <= state_d;
      d_y_q <= d_y_d;
      r_x_q <= r_x_d;
      r_y_q <= r_y_d;
      m_x_q <= m_x_d;
      m_y_q <= m_y_d;
      d_valid_q <= d_valid_d;
      r_valid_q <= r_valid_d;
      score_q <= score_d;
      lives_q <= lives_d;
      game_over_q <= game_over_d;
      rcnt_q <= rcnt_d;
      fcnt_q <= fcnt_d;
      ev_prev_q <= ev_prev_d;
    end
  end
  assign bus.d_x = D_X;
  assign bus.d_y = d_y_q;
  assign bus.r_x = r_x_q;
  assign bus.r_y = r_y_q;
  assign bus.m_x = m_x_q;
  assign bus.m_y = m_y_q;
  assign bus.d_valid = d_valid_q;
  assign bus.r_valid = r_valid_q;
  assign bus.score = score_q;
  assign bus.lives = lives_q;
  assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_object_ctrl.sv
// tb_object_ctrl: randomized and directed checks of object_ctrl against a behavioural game model
module tb_object_ctrl;
  logic clk_25Hz = 1'b0;
  logic rst = 1'b1;
  object_ctrl_if bus();
  object_ctrl dut (.clk_25Hz(clk_25Hz), .rst(rst), .bus(bus));
  always #20 clk_25Hz = ~clk_25Hz;
  int n_tests = 0, n_fail = 0;
  int ms, dy, rx, ry, mx, my, dv, rv, sc, lv, go, rc, fc, evp, lf;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lfsr_next(input int v);
    logic [7:0] s;
    s = 8'(v);
    return int'({s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]});
  endfunction
  task automatic model_reset();
    ms = 0; dy = 225; rx = 600; ry = 225; mx = 700; my = 0; dv = 0; rv = 0;
    sc = 0; lv = 3; go = 0; rc = 0; fc = 0; evp = 0; lf = 'hA5;
  endtask
  task automatic model_step(input bit tk, input bit up, input bit dn, input bit fire, input bit start, input int ev);
    bit nw, er, ed;
    int ndy, nlf, old_ms;
    nw = ev != 0 && ev != evp;
    er = nw && ms == 1 && (ev & 1) != 0;
    ed = nw && ms == 1 && (ev & 2) != 0;
    nlf = tk ? lfsr_next(lf) : lf;
    old_ms = ms;
    if (start && (ms == 0 || ms == 3)) begin
      model_reset();
      ms = 1; dv = 1; rv = 1;
      if (old_ms == 3) nlf = 'hA5;
    end else if (ms == 1) begin
      ndy = dy;
      if (tk && !ed && up != dn) ndy = up ? (dy >= 4 ? dy - 4 : 0) : (dy + 4 > 450 ? 450 : dy + 4);
      if (er) begin
        sc = sc < 255 ? sc + 1 : 255; rv = 0; rc = 60;
      end else if (tk && rv == 1) begin
        if (rx < 2) begin rx = 600; ry = 2 * lf > 450 ? 450 : 2 * lf; end
        else rx -= 2;
      end else if (tk) begin
        rc--;
        if (rc <= 0) begin rc = 0; rv = 1; rx = 600; ry = 225; end
      end
      if (er || ed) begin
        mx = 700; my = 0;
      end else if (tk && mx != 700) begin
        mx += 8;
        if (mx >= 640) begin mx = 700; my = 0; end
      end else if (tk && fire) begin
        mx = 80; my = dy;
      end
      dy = ndy;
      if (ed) begin
        lv--; dv = 0;
        if (lv == 0) begin ms = 3; go = 1; end
        else begin ms = 2; fc = 60; end
      end
    end else if (ms == 2 && tk) begin
      fc--;
      if (fc <= 0) begin fc = 0; ms = 1; dv = 1; dy = 225; rx = 600; ry = 225; rv = 1; rc = 0; end
    end
    evp = ev;
    lf = nlf;
  endtask
  task automatic compare_all();
    check("d_x", bus.d_x, 40);
    check("d_y", bus.d_y, dy);
    check("r_x", bus.r_x, rx);
    check("r_y", bus.r_y, ry);
    check("m_x", bus.m_x, mx);
    check("m_y", bus.m_y, my);
    check("d_valid", bus.d_valid, dv);
    check("r_valid", bus.r_valid, rv);
    check("score", bus.score, sc);
    check("lives", bus.lives, lv);
    check("game_over", bus.game_over, go);
  endtask
  task automatic step(input bit tk);
    bus.frame_tick = tk;
    @(posedge clk_25Hz);
    if (rst) model_reset();
    else model_step(tk, bus.key_up, bus.key_down, bus.key_fire, bus.key_start, int'(bus.Event));
    #1 compare_all();
  endtask
  task automatic start_game();
    bus.key_start = 1'b1;
    step(0);
    bus.key_start = 1'b0;
  endtask
  initial begin
    bus.frame_tick = 0; bus.key_up = 0; bus.key_down = 0; bus.key_fire = 0; bus.key_start = 0; bus.Event = 2'b00;
    rst = 1'b1;
    step(0);
    step(1);
    check("rst_d_y", bus.d_y, 225);
    check("rst_r_x", bus.r_x, 600);
    check("rst_m_x", bus.m_x, 700);
    check("rst_lives", bus.lives, 3);
    check("rst_valid", {bus.d_valid, bus.r_valid}, 0);
    rst = 1'b0;
    start_game();
    check("start_valid", {bus.d_valid, bus.r_valid}, 2'b11);
    bus.key_up = 1;
    repeat (10) begin step(1); step(0); end
    check("up10", bus.d_y, 185);
    repeat (60) step(1);
    check("up_sat", bus.d_y, 0);
    repeat (5) step(1);
    check("up_hold", bus.d_y, 0);
    bus.key_up = 0; bus.key_down = 1;
    repeat (25) step(1);
    check("down25", bus.d_y, 100);
    bus.key_down = 0; bus.key_fire = 1;
    step(1);
    check("fire_xy", {bus.m_x, bus.m_y}, {10'd80, 10'd100});
    bus.key_fire = 0;
    repeat (69) step(1);
    check("m_632", bus.m_x, 632);
    step(1);
    check("m_park", {bus.m_x, bus.m_y}, {10'd700, 10'd0});
    bus.key_fire = 1;
    step(1);
    check("refire", bus.m_x, 80);
    bus.key_fire = 0;
    bus.Event = 2'b01;
    step(0);
    check("ev01_score", bus.score, 1);
    repeat (59) step(1);
    check("r_dead59", bus.r_valid, 0);
    step(1);
    check("r_back", {bus.r_valid, bus.r_x, bus.r_y}, {1'b1, 10'd600, 10'd225});
    repeat (900) step(1'($urandom_range(0, 1)));
    check("ev01_once", bus.score, 1);
    bus.key_down = 1; bus.Event = 2'b11;
    step(1);
    check("ev11_sl", {bus.score, bus.lives}, {8'd2, 2'd2});
    check("ev11_dy", {bus.d_y, bus.d_valid}, {10'd100, 1'b0});
    bus.Event = 2'b00; bus.key_down = 0;
    repeat (60) step(1);
    check("resp_back", {bus.d_valid, bus.d_y}, {1'b1, 10'd225});
    rst = 1; step(0); rst = 0;
    start_game();
    for (int k = 0; k < 3; k++) begin
      bus.Event = 2'b10; step(0);
      bus.Event = 2'b00; step(0);
      check("lives_dec", bus.lives, 32'(2 - k));
      if (k < 2) begin
        repeat (59) step(1);
        check("resp_wait", bus.d_valid, 0);
        step(1);
        check("resp_done", bus.d_valid, 1);
      end
    end
    check("over", bus.game_over, 1);
    start_game();
    check("restart", {bus.lives, bus.game_over}, {2'd3, 1'b0});
    for (int i = 0; i < 20000; i++) begin
      bus.key_up = 1'($urandom_range(0, 1));
      bus.key_down = 1'($urandom_range(0, 1));
      bus.key_fire = $urandom_range(0, 3) == 0;
      bus.key_start = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 199) == 0) bus.Event = 2'($urandom_range(0, 3));
      rst = $urandom_range(0, 3999) == 0;
      step($urandom_range(0, 2) == 0);
    end
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/object_ctrl.md
OBJECT_CTRL -- requirements
Module: object_ctrl

Interface
REQ-001 SHALL have parameters D_STEP, 4, dragon pixels per frame; R_STEP, 2, robot pixels per frame; M_STEP, 8, missile pixels per frame.
REQ-002 SHALL have parameters RESPAWN_FRAMES, 60, frames before a dead object reappears; LIVES_INIT, 3, starting lives.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_25Hz in 1 pixel clock; rst in 1 reset.
REQ-004 SHALL have ports frame_tick in 1, one-cycle pulse per frame; key_up, key_down, key_fire, key_start in 1 each, level inputs.
REQ-005 SHALL have port Event in 2 collision code from the renderer: bit1 = dragon dies, bit0 = robot dies; each code is held for many frames.
REQ-006 SHALL have ports d_x, d_y, r_x, r_y, m_x, m_y out 10 each, sprite top-left positions; d_valid, r_valid out 1 each.
REQ-007 SHALL have ports score out 8, lives out 2, game_over out 1.

Function
REQ-008 SHALL implement FSM IDLE, PLAY, RESPAWN, OVER; all outputs registered.
REQ-009 IDLE->PLAY on key_start (any cycle); d_valid and r_valid SHALL rise on the next cycle.
REQ-010 Motion SHALL update only on frame_tick cycles in PLAY; new positions visible 1 cycle after the tick.
REQ-011 Dragon: key_up gives d_y-D_STEP, saturating at 0; key_down gives d_y+D_STEP, saturating at 450; both keys or neither gives no move; d_x fixed at 40.
REQ-012 Robot (r_valid=1): r_x -= R_STEP; when r_x < R_STEP, r_x<=600 and r_y<=min({lfsr,1'b0},450).
REQ-013 Missile fires when inactive and key_fire=1 on a tick: m_x<=d_x+40, m_y<=d_y; the fire frame itself SHALL NOT add M_STEP.
REQ-014 Active missile: m_x += M_STEP per tick; when the result is >=640 the missile SHALL deactivate and park at (700,0).
REQ-015 An inactive missile SHALL always sit at (700,0), off-screen for the renderer.
REQ-016 A new event SHALL be recognised only when Event!=0 and Event!=ev_prev; ev_prev registers Event every cycle in every state.
REQ-017 A new event SHALL be acted on only in PLAY; in other states it is ignored.
REQ-018 Event 01: score+1 saturating at 255; r_valid<=0; missile parked; robot respawn counter<=RESPAWN_FRAMES.
REQ-019 Robot respawn counter SHALL decrement per tick in PLAY; at 0, r_valid<=1 and robot at (600,225).
REQ-020 Event 10: lives-1; d_valid<=0; missile parked.
REQ-021 After Event 10, if lives becomes 0 the FSM SHALL go to OVER; otherwise RESPAWN with frame counter<=RESPAWN_FRAMES.
REQ-022 Event 11 SHALL apply both REQ-018 and REQ-020 in the same cycle.
REQ-023 Event on the same cycle as frame_tick: the event SHALL override motion for affected objects; unaffected objects move normally.
REQ-024 RESPAWN: all motion frozen; counter decrements per tick.
REQ-025 RESPAWN counter reaching 0: ->PLAY, d_valid<=1, d_y<=225, robot reset to (600,225), r_valid<=1.
REQ-026 OVER: game_over=1, positions hold; key_start re-initialises to reset values except state, then ->PLAY.

Reset
REQ-027 rst SHALL apply on any cycle, mid-operation included: state IDLE; d=(40,225), r=(600,225), m=(700,0); d_valid=r_valid=0; score=0; lives=LIVES_INIT; game_over=0; counters 0; ev_prev=0; lfsr=8'hA5.

Structure
REQ-028 Package obj_ctrl_pkg SHALL hold: state enum; SCREEN_W=640, SCREEN_H=480; sprite sizes 40x30 and 90x30; OFFSCREEN_X=700; Y_MAX=450; spawn coordinates.
REQ-029 SHALL instantiate one sub-module lfsr8: x^8+x^6+x^5+x^4+1, advances every frame_tick, seed 8'hA5.

Verification
REQ-030 Reset, key_start, 10 ticks with key_up -> d_y=185; 60 ticks with key_up -> d_y=0 and it stays 0.
REQ-031 In PLAY with r_x=601, 300 ticks -> r_x=1; next tick -> r_x=600, r_y=min(2*lfsr,450).
REQ-032 d_y=100, key_fire on a tick -> m=(80,100); 70 ticks -> m_x=640 gives park at (700,0); key_fire held -> refire next tick.
REQ-033 Event held at 01 for 1000 cycles -> score +1 exactly once; r_valid=0 for 60 ticks, then 1 at (600,225).
REQ-034 Three separate Event 10 pulses (each returned to 00 between) -> lives 2,1 with RESPAWN 60 ticks each, then OVER, game_over=1; key_start -> PLAY, lives=3.
REQ-035 Event 11 on the same cycle as frame_tick, key_down held -> score+1, lives-1, d_y unchanged, FSM=RESPAWN.
